// File: rtl/skip_sub_pkg.sv
// skip_sub_pkg: shared definitions for the sequential carry-skip subtractor.
//   - WIDTH_DEF / BLK_DEF / N_BLK_DEF : default geometry (32-bit, 4-bit blocks)
//   - state_e                         : IDLE -> RUN -> DONE control states
//   - calc_cw()                       : width of a counter that must reach n
//   - calc_iw()                       : width of a block index (at least 1 bit)
package skip_sub_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int BLK_DEF   = 4;
  localparam int N_BLK_DEF = WIDTH_DEF / BLK_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A counter that must hold the value n (inclusive) needs clog2(n+1) bits.
  function automatic int calc_cw(input int n);
    return $clog2(n + 1);
  endfunction

  // Index 0..n-1; keep one bit even for a single-block configuration.
  function automatic int calc_iw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/skip_subtractor32_seq_skip_block.sv
// skip_block: one combinational carry-skip stage, shared with the adder.
//   x, y    : BLK-bit operand slices (the subtractor feeds y = ~b)
//   cin     : carry into the block
//   sum     : x + y + cin, low BLK bits
//   cout    : carry out; taken straight from cin when every bit propagates
//   skipped : 1 when the bypass path supplied cout
module skip_block #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] x,
  input  logic [BLK-1:0] y,
  input  logic           cin,
  output logic [BLK-1:0] sum,
  output logic           cout,
  output logic           skipped
);

  logic [BLK-1:0] p;
  logic [BLK-1:0] g;
  logic [BLK:0]   c;

  assign p    = x ^ y;
  assign g    = x & y;
  assign c[0] = cin;

  for (genvar gi = 0; gi < BLK; gi++) begin : g_ripple
    assign c[gi+1] = g[gi] | (p[gi] & c[gi]);
  end

  assign sum     = p ^ c[BLK-1:0];
  assign skipped = &p;
  // When all bits propagate, the rippled carry equals cin anyway; the bypass
  // only shortens the path, so both branches give the same arithmetic result.
  assign cout    = skipped ? cin : c[BLK];

endmodule

// File: rtl/skip_subtractor32_seq.sv
// skip_subtractor32_seq: multi-cycle d = a - b - bin, one BLK-bit block per clock.
// Computed as a + ~b + ~bin through a carry-skip stage; the final carry is
// inverted to give the borrow.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (accepted only in IDLE)
//   a, b, bin            : minuend, subtrahend, borrow in
//   out_valid / out_ready: result handshake (held in DONE until out_ready)
//   d, bout              : difference mod 2^WIDTH, borrow out
//   skip_cnt             : number of blocks whose carry took the skip path
module skip_subtractor32_seq
  import skip_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int BLK   = BLK_DEF,
  localparam int N_BLK = WIDTH / BLK,
  localparam int CW    = calc_cw(WIDTH / BLK)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic [CW-1:0]    skip_cnt
);

  localparam int IW = calc_iw(N_BLK);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_BLK - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] nb_q, nb_d;       // subtrahend stored already inverted
  logic             c_q, c_d;         // carry into the current block
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    skip_q, skip_d;

  logic [BLK-1:0]   blk_x, blk_y, blk_sum;
  logic             blk_cout, blk_skipped;

  // Select the current block's operand slices with constant part-selects.
  always_comb begin
    blk_x = '0;
    blk_y = '0;
    for (int i = 0; i < N_BLK; i++) begin
      if (idx_q == IW'(i)) begin
        blk_x = a_q[i*BLK +: BLK];
        blk_y = nb_q[i*BLK +: BLK];
      end
    end
  end

  skip_block #(.BLK(BLK)) u_blk (
    .x       (blk_x),
    .y       (blk_y),
    .cin     (c_q),
    .sum     (blk_sum),
    .cout    (blk_cout),
    .skipped (blk_skipped)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    nb_d    = nb_q;
    c_d     = c_q;
    idx_d   = idx_q;
    d_d     = d_q;
    bout_d  = bout_q;
    skip_d  = skip_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          nb_d    = ~b;
          c_d     = ~bin;
          idx_d   = '0;
          skip_d  = '0;
          d_d     = '0;
          bout_d  = 1'b0;
          state_d = RUN;
        end
      end

      RUN: begin
        for (int i = 0; i < N_BLK; i++) begin
          if (idx_q == IW'(i)) begin
            d_d[i*BLK +: BLK] = blk_sum;
          end
        end
        c_d = blk_cout;
        if (blk_skipped) begin
          skip_d = skip_q + CW'(1);
        end
        if (idx_q == LAST_IDX) begin
          bout_d  = ~blk_cout;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      DONE: begin
        // in_valid is deliberately ignored here; a new operand waits for IDLE.
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      nb_q    <= '0;
      c_q     <= 1'b0;
      idx_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      nb_q    <= nb_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      skip_q  <= skip_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign d         = d_q;
  assign bout      = bout_q;
  assign skip_cnt  = skip_q;

endmodule

// File: tb/tb_skip_subtractor32_seq.sv
// tb_skip_subtractor32_seq: directed vectors for skip_subtractor32_seq with
// hand-computed expected differences, borrows, skip counts and latency.
module tb_skip_subtractor32_seq;

  localparam int WIDTH = 32;
  localparam int CW    = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic [CW-1:0]    skip_cnt;

  int checks   = 0;
  int failures = 0;

  skip_subtractor32_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
    .skip_cnt  (skip_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one operation. Latency counts clock edges starting with the
  // acceptance edge; out_valid must be seen after edge 9.
  // exp_skip < 0 skips the skip_cnt comparison. hold = extra DONE cycles with
  // out_ready low. overlap = raise in_valid together with out_ready.
  task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                       input logic tbin, input logic [31:0] exp_d, input logic exp_bout,
                       input int exp_skip, input int hold, input bit toggle, input bit overlap);
    int cycles;
    int wait_cnt;
    int bad;
    logic [31:0] d_snap;
    logic        bout_snap;
    logic [CW-1:0] skip_snap;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 50) begin
      @(posedge clk); @(negedge clk); wait_cnt++;
    end
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    a = ta; b = tbv; bin = tbin; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cycles = 1;
    while (!out_valid && cycles < 40) begin
      if (toggle) begin
        a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
      end
      check({tag, "_busy_in_ready"}, 64'(in_ready), 64'd0);
      @(posedge clk); @(negedge clk);
      cycles++;
    end
    check({tag, "_latency"}, 64'(cycles), 64'd9);
    check({tag, "_d"}, 64'(d), 64'(exp_d));
    check({tag, "_bout"}, 64'(bout), 64'(exp_bout));
    if (exp_skip >= 0) check({tag, "_skip_cnt"}, 64'(skip_cnt), 64'(exp_skip));
    d_snap = d; bout_snap = bout; skip_snap = skip_cnt;
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = 32'h1234; b = 32'h1;   // must be ignored in DONE
      @(posedge clk); @(negedge clk);
      if (d !== d_snap || bout !== bout_snap || skip_cnt !== skip_snap ||
          in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    in_valid = 1'b0;
    if (hold > 0) check({tag, "_hold_unstable_cycles"}, 64'(bad), 64'd0);
    out_ready = 1'b1;
    if (overlap) begin
      in_valid = 1'b1; a = 32'd99; b = 32'd1; bin = 1'b0;
    end
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    check({tag, "_retire_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_retire_in_ready"}, 64'(in_ready), 64'd1);
    $display("op %s: a=%0d b=%0d bin=%0d -> d=0x%08h bout=%0d skip=%0d lat=%0d",
             tag, ta, tbv, tbin, d_snap, bout_snap, skip_snap, cycles);
  endtask

  initial begin
    int pulses;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_d", 64'(d), 64'd0);
    check("reset_bout", 64'(bout), 64'd0);
    check("reset_skip_cnt", 64'(skip_cnt), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_valid_in_ready", 64'(in_ready), 64'd1);

    do_op("sub_10_5_1",   32'd10,     32'd5,      1'b1, 32'd4,          1'b0, 7, 0, 1'b0, 1'b0);
    do_op("sub_37_48_0",  32'd37,     32'd48,     1'b0, 32'hFFFF_FFF5,  1'b1, 6, 0, 1'b0, 1'b0);
    do_op("sub_127_127_1",32'd127,    32'd127,    1'b1, 32'hFFFF_FFFF,  1'b1, 8, 0, 1'b0, 1'b1);
    do_op("sub_0_0_0",    32'd0,      32'd0,      1'b0, 32'd0,          1'b0, 8, 0, 1'b0, 1'b0);
    do_op("sub_hold",     32'd641322, 32'd542343, 1'b0, 32'd98979,      1'b0, -1, 5, 1'b0, 1'b0);

    // Reset during the 4th RUN cycle: accept, let 3 RUN edges pass, then reset.
    a = 32'd70000; b = 32'd7776; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_d", 64'(d), 64'd0);
    check("midrst_skip_cnt", 64'(skip_cnt), 64'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) pulses++;
    end
    check("midrst_no_pulse", 64'(pulses), 64'd0);

    do_op("sub_16000_5000_1", 32'd16000, 32'd5000, 1'b1, 32'd10999, 1'b0, -1, 0, 1'b0, 1'b0);
    do_op("sub_toggle",       32'd245,   32'd2,    1'b0, 32'd243,   1'b0, -1, 0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
